div: RTL and testbench

DIV -- requirements
Module: div

---
 rtl/div_pkg.sv | 26 ++
 rtl/div.sv | 108 ++++++++++
 tb/tb_div.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// Shared encodings and helpers for the multi-cycle divider.
package div_pkg;

    // FSM state encodings
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;
    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

    // Number of shift-subtract iterations for a 32-bit quotient
    localparam logic [5:0]  DivIters          = 6'd32;

    // Two's-complement negate when neg is set, pass-through otherwise
    function automatic logic [31:0] cond_negate(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider for div/divu. Returns {remainder, quotient}
// 33 cycles after the start edge; divide-by-zero yields zero after one cycle.
module div
    import div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state;
    logic [5:0]  cnt;
    // [64:33] partial remainder, [31:0] quotient bits as they are formed
    logic [64:0] dividend;
    logic [31:0] divisor;
    logic        neg_quo;
    logic        neg_rem;

    logic [32:0] trial;
    logic [31:0] abs_op1;
    logic [31:0] abs_op2;
    logic [31:0] quo_fixed;
    logic [31:0] rem_fixed;

    // Trial subtraction, operand magnitudes and final sign fixup
    always_comb begin
        // Shifted remainder can need 33 bits when the divisor is large
        trial     = dividend[64:32] - {1'b0, divisor};
        abs_op1   = cond_negate(opdata1_i, signed_div_i & opdata1_i[31]);
        abs_op2   = cond_negate(opdata2_i, signed_div_i & opdata2_i[31]);
        quo_fixed = cond_negate(dividend[31:0], neg_quo);
        rem_fixed = cond_negate(dividend[64:33], neg_rem);
    end

    // Control FSM plus iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= DivFree;
            cnt      <= 6'd0;
            dividend <= 65'd0;
            divisor  <= ZeroWord;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            result_o <= {ZeroWord, ZeroWord};
            ready_o  <= DivResultNotReady;
        end else begin
            unique case (state)
                DivFree: begin
                    if (start_i == DivStart && !annul_i) begin
                        cnt      <= 6'd0;
                        dividend <= {32'd0, abs_op1, 1'b0};
                        divisor  <= abs_op2;
                        neg_quo  <= signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                        neg_rem  <= signed_div_i & opdata1_i[31];
                        state    <= (opdata2_i == ZeroWord) ? DivByZero : DivOn;
                    end
                end
                DivByZero: begin
                    if (annul_i) begin
                        state    <= DivFree;
                        cnt      <= 6'd0;
                        result_o <= {ZeroWord, ZeroWord};
                        ready_o  <= DivResultNotReady;
                    end else begin
                        state    <= DivEnd;
                        result_o <= {ZeroWord, ZeroWord};
                        ready_o  <= DivResultReady;
                    end
                end
                DivOn: begin
                    if (annul_i) begin
                        state    <= DivFree;
                        cnt      <= 6'd0;
                        result_o <= {ZeroWord, ZeroWord};
                        ready_o  <= DivResultNotReady;
                    end else if (cnt != DivIters) begin
                        if (trial[32]) begin
                            dividend <= {dividend[63:0], 1'b0};
                        end else begin
                            dividend <= {trial[31:0], dividend[31:0], 1'b1};
                        end
                        cnt <= cnt + 6'd1;
                    end else begin
                        state    <= DivEnd;
                        cnt      <= 6'd0;
                        result_o <= {rem_fixed, quo_fixed};
                        ready_o  <= DivResultReady;
                    end
                end
                DivEnd: begin
                    if (start_i == DivStop) begin
                        state    <= DivFree;
                        result_o <= {ZeroWord, ZeroWord};
                        ready_o  <= DivResultNotReady;
                    end
                end
                default: state <= DivFree;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed self-checking bench for the multi-cycle divider.
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int checks = 0;
    int passed = 0;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; sample and drive 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one request, measure latency from the start edge, check result, release
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp,
                           input int exp_lat);
        int lat;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        tick();                       // E0
        opdata1_i = 32'h1234_5678;    // must be ignored after latching
        opdata2_i = 32'h0000_0003;
        lat = 0;
        while (!ready_o && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_res"}, result_o, exp);
        start_i = 1'b0;
        tick();
        check({tag, "_rel"}, {63'd0, ready_o}, 64'd0);
    endtask

    initial begin
        logic seen;
        rst = 1'b1; signed_div_i = 1'b0; opdata1_i = '0; opdata2_i = '0;
        start_i = 1'b0; annul_i = 1'b0;
        tick();
        tick();
        check("reset_ready", {63'd0, ready_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        rst = 1'b0;
        tick();

        // divu 100/7 with exact latency and hold while start stays high
        signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
        tick();                               // E0
        opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'd1;
        for (int i = 0; i < 32; i++) tick();  // E1..E32
        check("divu100_e32_ready", {63'd0, ready_o}, 64'd0);
        tick();                               // E33
        check("divu100_e33_ready", {63'd0, ready_o}, 64'd1);
        check("divu100_result", result_o, {32'h0000_0002, 32'h0000_000E});
        tick();
        check("divu100_hold_ready", {63'd0, ready_o}, 64'd1);
        check("divu100_hold_result", result_o, {32'h0000_0002, 32'h0000_000E});
        start_i = 1'b0;
        tick();
        check("divu100_free_ready", {63'd0, ready_o}, 64'd0);
        check("divu100_free_result", result_o, 64'd0);

        // Signed cases: -7/2, 7/-2, -100/-7, and the overflow corner
        run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002,
                {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("div_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE,
                {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run_div("div_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9,
                {32'hFFFF_FFFE, 32'h0000_000E}, 33);
        // Large unsigned divisor needs the full 33-bit trial
        run_div("divu_big", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE,
                {32'h0000_0001, 32'h0000_0001}, 33);

        // Divide by zero
        signed_div_i = 1'b0; opdata1_i = 32'd55; opdata2_i = 32'd0; start_i = 1'b1;
        tick();                               // E0
        check("byzero_e0_ready", {63'd0, ready_o}, 64'd0);
        tick();                               // E1
        check("byzero_e1_ready", {63'd0, ready_o}, 64'd1);
        check("byzero_e1_result", result_o, 64'd0);
        tick();                               // E2
        check("byzero_e2_ready", {63'd0, ready_o}, 64'd1);
        start_i = 1'b0;
        tick();
        check("byzero_release", {63'd0, ready_o}, 64'd0);

        // Annul at the 10th iteration cycle
        signed_div_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
        tick();                               // E0
        for (int i = 0; i < 9; i++) tick();   // E1..E9
        annul_i = 1'b1; start_i = 1'b0;
        tick();                               // E10
        annul_i = 1'b0;
        check("annul_ready", {63'd0, ready_o}, 64'd0);
        check("annul_result", result_o, 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen = seen | ready_o;
        end
        check("annul_no_ready", {63'd0, seen}, 64'd0);
        run_div("divu_ffff_10", 1'b0, 32'hFFFF_FFFF, 32'h0000_0010,
                {32'h0000_000F, 32'h0FFF_FFFF}, 33);

        // start with annul in FREE is ignored
        signed_div_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd3;
        start_i = 1'b1; annul_i = 1'b1;
        tick();
        start_i = 1'b0; annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            seen = seen | ready_o;
        end
        check("free_annul_ignored", {63'd0, seen}, 64'd0);

        // Reset mid-ON at cycle 20
        signed_div_i = 1'b0; opdata1_i = 32'd12345; opdata2_i = 32'd11; start_i = 1'b1;
        tick();                               // E0
        for (int i = 0; i < 19; i++) tick();
        rst = 1'b1;
        tick();
        check("midrst_ready", {63'd0, ready_o}, 64'd0);
        check("midrst_result", result_o, 64'd0);
        rst = 1'b0; start_i = 1'b0;
        tick();
        seen = 1'b0;
        for (int i = 0; i < 36; i++) begin
            tick();
            seen = seen | ready_o;
        end
        check("midrst_no_ready", {63'd0, seen}, 64'd0);
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
                {32'h0000_0000, 32'h8000_0000}, 33);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
